// File: rtl/nios_oscdiv_pkg.sv
// Shared constants for the multi-channel oscillator divider: register map,
// STATUS field positions and the channel-count ceiling.
package nios_oscdiv_pkg;

  localparam int N_CH_MAX = 4;

  localparam logic [2:0] ADDR_DIV0     = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

  localparam int STATUS_OSC_LSB  = 0;
  localparam int STATUS_WRAP_LSB = 8;

endpackage

// File: rtl/nios_oscdiv_channel.sv
// One divider channel: shadow/active divisor, half-period counter, toggle
// output and wrap flag (flag only exists when NIOS_OSCDIV_IRQ_EN is defined).
module nios_oscdiv_channel #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_wdata,
  input  logic             flag_clr,
  output logic [DIV_W-1:0] shadow,
  output logic             osc,
  output logic             wrap_flag
);

  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] next_active;
  logic             idle;
  logic             wrap;

  // A divisor written in the same cycle as a reload bypasses the shadow copy.
  assign next_active = div_we ? div_wdata : shadow;
  assign idle        = !run || (active == '0);
  assign wrap        = !idle && (count == active - DIV_W'(1));

  // Divisor registers, counter and output toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
      count  <= '0;
      osc    <= 1'b0;
    end else begin
      if (div_we) begin
        shadow <= div_wdata;
      end
      if (idle) begin
        count  <= '0;
        osc    <= 1'b0;
        active <= next_active;
      end else if (wrap) begin
        count  <= '0;
        osc    <= ~osc;
        active <= next_active;
      end else begin
        count  <= count + DIV_W'(1);
      end
    end
  end

`ifdef NIOS_OSCDIV_IRQ_EN
  // Sticky flag on each rising edge of osc; a set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_flag <= 1'b0;
    end else if (wrap && !osc) begin
      wrap_flag <= 1'b1;
    end else if (flag_clr) begin
      wrap_flag <= 1'b0;
    end
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign wrap_flag       = 1'b0;
`endif

endmodule

// File: rtl/nios_oscdiv_multi.sv
// Avalon-MM multi-channel square-wave divider. Define NIOS_OSCDIV_IRQ_EN to
// enable wrap flags, IRQ_MASK and the interrupt; otherwise irq is tied low.
module nios_oscdiv_multi
  import nios_oscdiv_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int DIV_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      address,
  input  logic            chipselect,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [N_CH-1:0] osc_out,
  output logic            irq
);

  logic             wr;
  logic [N_CH-1:0]  ctrl;
  logic [N_CH-1:0]  ctrl_stop;
  logic [N_CH-1:0]  run;
  logic [N_CH-1:0]  wrap_flags;
  logic [N_CH-1:0]  irq_mask;
  logic [DIV_W-1:0] shadow [N_CH];
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // A disabling CTRL write stops the channel at that edge, so osc drops next cycle;
  // an enabling write only takes effect after the edge, so counting starts at 0.
  assign ctrl_stop = (wr && address == ADDR_CTRL) ? ~writedata[N_CH-1:0] : '0;
  assign run       = ctrl & ~ctrl_stop;

  // Channel enable register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr && address == ADDR_CTRL) begin
      ctrl <= writedata[N_CH-1:0];
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    nios_oscdiv_channel #(.DIV_W(DIV_W)) u_channel (
      .clk       (clk),
      .reset     (reset),
      .run       (run[ch]),
      .div_we    (wr && address == ADDR_DIV0 + 3'(ch)),
      .div_wdata (writedata[DIV_W-1:0]),
      .flag_clr  (wr && address == ADDR_STATUS && writedata[STATUS_WRAP_LSB + ch]),
      .shadow    (shadow[ch]),
      .osc       (osc_out[ch]),
      .wrap_flag (wrap_flags[ch])
    );
  end

`ifdef NIOS_OSCDIV_IRQ_EN
  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr && address == ADDR_IRQ_MASK) begin
      irq_mask <= writedata[N_CH-1:0];
    end
  end
  assign irq = |(wrap_flags & irq_mask);
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  // Zero-wait-state read mux; unmapped addresses and absent channels read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: readdata[N_CH-1:0] = ctrl;
      ADDR_STATUS: begin
        readdata[STATUS_OSC_LSB +: N_CH]  = osc_out;
        readdata[STATUS_WRAP_LSB +: N_CH] = wrap_flags;
      end
      ADDR_IRQ_MASK: readdata[N_CH-1:0] = irq_mask;
      default: begin
        for (int ch = 0; ch < N_CH; ch++) begin
          readdata = readdata | ((address == 3'(ch)) ? 32'(shadow[ch]) : 32'd0);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_nios_oscdiv_multi.sv
// Self-checking bench for nios_oscdiv_multi: directed scenarios plus randomized
// bus traffic against a remaining-cycles reference model.
module tb_nios_oscdiv_multi;

  localparam int N_CH  = 2;
  localparam int DIV_W = 16;
`ifdef NIOS_OSCDIV_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      address;
  logic            chipselect;
  logic            write_n;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic [N_CH-1:0] osc_out;
  logic            irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: divisors and cycles left until the next toggle.
  int m_shadow [4];
  int m_active [4];
  int m_left   [4];
  bit m_en     [4];
  bit m_osc    [4];
  bit m_flag   [4];
  bit [3:0] m_mask;

  nios_oscdiv_multi #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .osc_out(osc_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_shadow[ch] = 0; m_active[ch] = 0; m_left[ch] = 0;
      m_en[ch] = 1'b0; m_osc[ch] = 1'b0; m_flag[ch] = 1'b0;
    end
    m_mask = 4'd0;
  endtask

  task automatic model_step();
    bit wr;
    wr = chipselect && !write_n;
    for (int ch = 0; ch < N_CH; ch++) begin
      bit divw, stop, rose;
      int nxt;
      divw = wr && (address == 3'(ch));
      stop = wr && (address == 3'd4) && !writedata[ch];
      nxt  = divw ? int'(writedata[DIV_W-1:0]) : m_shadow[ch];
      rose = 1'b0;
      if (m_en[ch] && !stop && m_active[ch] != 0) begin
        m_left[ch] = m_left[ch] - 1;
        if (m_left[ch] == 0) begin
          m_osc[ch]    = !m_osc[ch];
          rose         = m_osc[ch];
          m_active[ch] = nxt;
          m_left[ch]   = nxt;
        end
      end else begin
        m_osc[ch]    = 1'b0;
        m_active[ch] = nxt;
        m_left[ch]   = nxt;
      end
      if (IRQ_EN) begin
        if (rose) m_flag[ch] = 1'b1;
        else if (wr && address == 3'd5 && writedata[8 + ch]) m_flag[ch] = 1'b0;
      end
      if (divw) m_shadow[ch] = nxt;
      if (wr && address == 3'd4) m_en[ch] = writedata[ch];
    end
    if (IRQ_EN && wr && address == 3'd6) m_mask = writedata[3:0] & 4'((1 << N_CH) - 1);
  endtask

  function automatic logic [N_CH-1:0] exp_osc();
    logic [N_CH-1:0] v;
    for (int ch = 0; ch < N_CH; ch++) v[ch] = m_osc[ch];
    return v;
  endfunction

  function automatic logic exp_irq();
    logic v = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) v = v | (m_flag[ch] & m_mask[ch]);
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [31:0] v = 32'd0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (a == 3'(ch)) v = 32'(m_shadow[ch]);
      if (a == 3'd4) v[ch] = m_en[ch];
      if (a == 3'd5) begin v[ch] = m_osc[ch]; v[8 + ch] = m_flag[ch]; end
      if (a == 3'd6) v[ch] = m_mask[ch];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (osc_out !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: osc_out=%b irq=%b, required 0 0", osc_out, irq);
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      n_tests++;
      if (readdata !== 32'd0) begin
        n_fail++; $display("FAIL reset_read addr %0d: got %h, required 0", a, readdata);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cnt;
    do_reset();
    bus_write(3'd0, 32'd3);
    bus_write(3'd4, 32'd1);
    cnt = 0;
    while (osc_out[0] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 3) begin n_fail++; $display("FAIL basic_first_rise: %0d cycles, required 3", cnt); end
    cnt = 0;
    while (osc_out[0] === 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 3) begin n_fail++; $display("FAIL basic_high_time: %0d cycles, required 3", cnt); end
    cnt = 0;
    while (osc_out[0] === 1'b0 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 3) begin n_fail++; $display("FAIL basic_low_time: %0d cycles, required 3", cnt); end
    for (int i = 0; i < 24; i++) begin
      tick();
      n_tests++;
      if (osc_out !== exp_osc()) begin
        n_fail++; $display("FAIL basic_wave cyc %0d: osc_out=%b, required %b", i, osc_out, exp_osc());
      end
    end
  endtask

  task automatic test_reload();
    int cnt;
    // Mid-count write: current half-period keeps 4, later ones use 2.
    do_reset();
    bus_write(3'd0, 32'd4);
    bus_write(3'd4, 32'd1);
    cnt = 0;
    while (osc_out[0] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    cnt = 0;
    tick(); cnt++;
    bus_write(3'd0, 32'd2); cnt++;
    while (osc_out[0] === 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 4) begin n_fail++; $display("FAIL reload_mid_current: %0d cycles, required 4", cnt); end
    cnt = 0;
    while (osc_out[0] === 1'b0 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 2) begin n_fail++; $display("FAIL reload_mid_next: %0d cycles, required 2", cnt); end
    // Write landing in the wrap cycle takes effect at once.
    do_reset();
    bus_write(3'd0, 32'd4);
    bus_write(3'd4, 32'd1);
    cnt = 0;
    while (osc_out[0] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    for (int i = 0; i < 3; i++) tick();
    bus_write(3'd0, 32'd2);
    n_tests++;
    if (osc_out[0] !== 1'b0) begin n_fail++; $display("FAIL reload_wrap_fall: osc_out[0]=%b, required 0", osc_out[0]); end
    cnt = 0;
    while (osc_out[0] === 1'b0 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 2) begin n_fail++; $display("FAIL reload_wrap_next: %0d cycles, required 2", cnt); end
  endtask

  task automatic test_zero_div();
    int bad = 0;
    do_reset();
    bus_write(3'd4, 32'd1);
    for (int i = 0; i < 10; i++) begin tick(); if (osc_out[0] !== 1'b0) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL zero_div_hold: %0d high samples, required 0", bad); end
    bus_write(3'd0, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (osc_out[0] !== 1'((i + 1) % 2)) begin
        n_fail++; $display("FAIL div1_toggle cyc %0d: osc_out[0]=%b, required %0d", i, osc_out[0], (i + 1) % 2);
      end
    end
  endtask

  task automatic test_disable();
    int cnt;
    int bad = 0;
    do_reset();
    bus_write(3'd1, 32'd3);
    bus_write(3'd4, 32'd2);
    cnt = 0;
    while (osc_out[1] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tick();
    bus_write(3'd4, 32'd0);
    n_tests++;
    if (osc_out[1] !== 1'b0) begin n_fail++; $display("FAIL disable_low: osc_out[1]=%b, required 0", osc_out[1]); end
    for (int i = 0; i < 6; i++) begin tick(); if (osc_out[1] !== 1'b0) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL disable_hold: %0d high samples, required 0", bad); end
    bus_write(3'd4, 32'd2);
    cnt = 0;
    while (osc_out[1] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_tests++;
    if (cnt != 3) begin n_fail++; $display("FAIL reenable_rise: %0d cycles, required 3", cnt); end
  endtask

  task automatic test_irq();
    int cnt;
    int bad = 0;
    do_reset();
`ifdef NIOS_OSCDIV_IRQ_EN
    bus_write(3'd6, 32'd2);
    bus_write(3'd1, 32'd2);
    bus_write(3'd4, 32'd2);
    cnt = 0;
    while (osc_out[1] !== 1'b1 && cnt < 20) begin
      if (irq !== 1'b0) bad++;
      tick(); cnt++;
    end
    n_tests++;
    if (irq !== 1'b1 || bad != 0) begin
      n_fail++; $display("FAIL irq_rise: irq=%b early=%0d, required 1 0", irq, bad);
    end
    bus_write(3'd5, 32'h200);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b, required 0", irq); end
    bus_write(3'd6, 32'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (irq !== 1'b0) bad++; end
    address = 3'd5; #1;
    n_tests++;
    if (bad != 0 || readdata[9] !== 1'b1) begin
      n_fail++; $display("FAIL irq_masked: irq highs=%0d flag=%b, required 0 1", bad, readdata[9]);
    end
`else
    bus_write(3'd6, 32'hF);
    bus_write(3'd1, 32'd2);
    bus_write(3'd4, 32'd2);
    for (int i = 0; i < 12; i++) begin tick(); if (irq !== 1'b0) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL irq_tied: %0d high samples, required 0", bad); end
    address = 3'd6; #1;
    n_tests++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL mask_read: got %h, required 0", readdata); end
    address = 3'd5; #1;
    n_tests++;
    if (readdata[11:8] !== 4'd0) begin n_fail++; $display("FAIL flags_read: got %h, required 0", readdata[11:8]); end
`endif
  endtask

  task automatic test_random();
    logic [2:0] a;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        a = 3'($urandom_range(0, 7));
        d = (a < 3'd4) ? 32'($urandom_range(0, 5)) : $urandom;
        bus_write(a, d);
      end else begin
        tick();
      end
      n_tests++;
      if (osc_out !== exp_osc() || irq !== exp_irq()) begin
        n_fail++; $display("FAIL random_out cyc %0d: osc_out=%b irq=%b, required %b %b",
                           i, osc_out, irq, exp_osc(), exp_irq());
      end
      address = 3'($urandom_range(0, 7)); #1;
      n_tests++;
      if (readdata !== exp_read(address)) begin
        n_fail++; $display("FAIL random_read cyc %0d addr %0d: got %h, required %h",
                           i, address, readdata, exp_read(address));
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    bus_write(3'd0, 32'd5);
    bus_write(3'd1, 32'd2);
    bus_write(3'd3, 32'h1234);
    bus_write(3'd4, 32'd3);
    address = 3'd3; #1;
    n_tests++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL div3_read: got %h, required 0", readdata); end
    address = 3'd7; #1;
    n_tests++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL addr7_read: got %h, required 0", readdata); end
    for (int i = 0; i < 7; i++) tick();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (osc_out !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_out: osc_out=%b irq=%b, required 0 0", osc_out, irq);
    end
    for (int a = 0; a < 7; a++) begin
      address = 3'(a); #1;
      n_tests++;
      if (readdata !== 32'd0) begin
        n_fail++; $display("FAIL async_reset_read addr %0d: got %h, required 0", a, readdata);
      end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (osc_out !== '0) bad++; end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL post_reset_idle: %0d nonzero samples, required 0", bad); end
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_reload();
    test_zero_div();
    test_disable();
    test_irq();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
